// File: rtl/ce_chain_gen.sv
// rtl/ce_chain_gen.sv - base prescaler plus cascaded runtime-programmable clock-enable channels
module ce_chain_gen #(
    parameter int FCLK     = 50000000,
    parameter int F_BASE   = 1000,
    parameter int BASE_W   = 26,
    parameter int N_CH     = 3,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 10
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic                                    restart,
    input  logic                                    div_ld,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] div_ch,
    input  logic [DIV_W-1:0]                        div_val,
    output logic                                    ce_base,
    output logic [N_CH-1:0]                         ce
);
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BASE_DIV = FCLK / F_BASE;

    if (BASE_DIV < 2) begin : g_err_base_div
        $error("ce_chain_gen: FCLK / F_BASE must be at least 2");
    end
    if ((longint'(BASE_DIV) >> BASE_W) != 0) begin : g_err_base_w
        $error("ce_chain_gen: BASE_W too narrow for FCLK / F_BASE");
    end
    if (N_CH < 1 || N_CH > 8) begin : g_err_n_ch
        $error("ce_chain_gen: N_CH must be 1..8");
    end
    if (DIV_INIT < 1 || (longint'(DIV_INIT) >> DIV_W) != 0) begin : g_err_div_init
        $error("ce_chain_gen: DIV_INIT must be at least 1 and fit DIV_W");
    end

    logic [BASE_W-1:0] bcnt;
    logic              base_hit;
    logic [N_CH:0]     chain;

    assign base_hit = (bcnt == BASE_W'(1));
    // restart silences every strobe in its own cycle; gating the root gates the whole cascade
    assign ce_base  = en & ~restart & base_hit;
    assign chain[0] = ce_base;
    assign ce       = chain[N_CH:1];

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            bcnt <= BASE_W'(BASE_DIV);
        end else if (en) begin
            bcnt <= base_hit ? BASE_W'(BASE_DIV) : bcnt - BASE_W'(1);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] pend_q;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] pend_nxt;
        logic             wr;
        logic             src;
        logic             wrap;
        logic             off;

        assign src      = chain[k];
        assign wr       = div_ld & (div_ch == CH_W'(k));
        assign pend_nxt = wr ? div_val : pend_q;
        assign wrap     = (cnt_q == DIV_W'(1));
        assign off      = (cnt_q == '0) & (div_q == '0);
        assign chain[k+1] = src & wrap & (div_q != '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                div_q  <= DIV_W'(DIV_INIT);
                pend_q <= DIV_W'(DIV_INIT);
                cnt_q  <= DIV_W'(DIV_INIT);
            end else if (restart) begin
                pend_q <= pend_nxt;
                div_q  <= pend_nxt;
                cnt_q  <= pend_nxt;
            end else begin
                pend_q <= pend_nxt;
                // a disabled channel has no wrap to wait for, so a nonzero write starts it at once
                if (wr && off && div_val != '0) begin
                    div_q <= div_val;
                    cnt_q <= div_val;
                end else if (src && wrap) begin
                    div_q <= pend_nxt;
                    cnt_q <= pend_nxt;
                end else if (src && cnt_q != '0) begin
                    cnt_q <= cnt_q - DIV_W'(1);
                end
            end
        end
    end
endmodule
